rx_byte_aligner: RTL
====================

# rx_byte_aligner

Receive-side 16-bit byte aligner between the GT RX datapath (rxdata/rxcharisk after the RX buffer) and the latency checker. It detects the IDLE comma in either byte lane, locks a byte offset after repeated confirmation, and presents realigned data, K flags and an `aligned_o` indication that drives the checker's `rx_aligned_i`. The checker's `rx_realign_o` is the permission input that lets the aligner change offset.

## Interface
- `g_IDLE`, 16'hbc95: IDLE word; comma byte is `g_IDLE[15:8]` (K28.5) and belongs in the high lane.
- `g_LOCK_COUNT`, 4: consecutive commas in the same lane required to lock.
- `g_LOSS_COUNT`, 3: consecutive wrong-lane commas that drop lock.
- `g_COMMA_TIMEOUT`, 400: maximum cycles without an expected-lane comma before lock is dropped (must exceed 2×IDLE period).

Ports:
- `usrclk_i` in 1: GT user clock, the only clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `rx_valid_i` in 1: GT RX data valid (reset done, buffer OK).
- `rx_data_i` in 16: raw RX data.
- `rx_k_i` in 2: raw K flags; bit 1 is the high lane.
- `realign_i` in 1: permission to acquire or change the offset.
- `data_o` out 16: aligned data.
- `k_o` out 2: aligned K flags.
- `valid_o` out 1: `data_o`/`k_o` meaningful.
- `aligned_o` out 1: lock indication.
- `offset_o` out 1: 0 = pass-through, 1 = one-byte shift.
- `lock_loss_cnt_o` out 8: LOCKED→HUNT transitions, saturating at 255.

## Operation
- Reset values: `data_o`=0, `k_o`=0, `valid_o`=0, `aligned_o`=0, `offset_o`=0, `lock_loss_cnt_o`=0. State is HUNT and all counters are 0.
- Comma detection on the raw input:
  - hi_comma = `rx_k_i[1]` && `rx_data_i[15:8]`==`g_IDLE[15:8]`.
  - lo_comma = `rx_k_i[0]` && `rx_data_i[7:0]`==`g_IDLE[15:8]`.
  - Candidate offset is 0 for hi_comma and 1 for lo_comma.
  - Both set at once is a bad comma: it is never a candidate and counts as a wrong-lane comma.
- Shifter: the previous raw word and K flags are held in a register.
  - Offset 0: out = cur.
  - Offset 1: out = {prev[7:0], cur[15:8]}, k = {prev_k[0], cur_k[1]}.
- HUNT state:
  - `aligned_o`=0.
  - If `realign_i`=1 and exactly one comma lane is set: load `offset_o` with the candidate, set ok_cnt=1, go to VERIFY.
  - If `realign_i`=0: `offset_o` is frozen.
- VERIFY state:
  - Expected-lane comma: ok_cnt+1. When ok_cnt reaches `g_LOCK_COUNT`, go to LOCKED.
  - Wrong-lane or bad comma, or timeout: go to HUNT with ok_cnt=0.
- LOCKED state:
  - `aligned_o`=1.
  - Expected-lane comma: clears err_cnt and the timeout counter.
  - Wrong-lane or bad comma: err_cnt+1. At `g_LOSS_COUNT`, go to HUNT.
  - Timeout: go to HUNT.
  - `realign_i` is ignored.
  - Every LOCKED→HUNT transition increments `lock_loss_cnt_o`, saturating at 255.
- Timeout counter: counts cycles since the last expected-lane comma in VERIFY/LOCKED. It reaches the limit at `g_COMMA_TIMEOUT`.
- `rx_valid_i`=0 on any cycle:
  - Next state is HUNT and ok_cnt, err_cnt and the timeout counter are cleared.
  - `valid_o`=0 on the following cycle.
  - `offset_o` is retained.
  - `lock_loss_cnt_o` increments only if the block was LOCKED.
- Precedence when events coincide: invalid > loss/timeout > comma handling.

## Timing
- Latency: `data_o`/`k_o`/`valid_o` are registered, so there is one cycle from `rx_data_i` to `data_o` for offset 0. For offset 1, the high byte originates two cycles earlier.
- `valid_o` = registered (`rx_valid_i` && (`offset_o`=0 || prev word valid)).
- `aligned_o` rises in the cycle after the `g_LOCK_COUNT`-th matching comma is sampled. It falls in the cycle after the loss event.
- An offset change takes effect on `data_o` in the cycle after the acquiring comma. That first output word is already shifted.
- Asserting `rst_n_i` mid-lock clears all outputs immediately, with no clock edge needed.

## Structure
- Shared package/include holds: state encoding (HUNT, VERIFY, LOCKED), comma byte constant derived from `g_IDLE`, and counter widths via `$clog2(g_COMMA_TIMEOUT+1)`.
- One sub-module, `rx_byte_shift`: the previous-word register plus the offset mux. The top level holds the detector, FSM and counters.

## Test plan
- **Aligned stream.** Counter data with 16'hbc95/K=2'b10 every 193 words, `realign_i`=1. Required response: `offset_o`=0, and `aligned_o` rises one cycle after the 4th IDLE. `data_o` equals input delayed by one cycle.
- **Byte-slipped stream.** Same stream shifted by one byte (comma arriving with K=2'b01). Required response: `offset_o`=1, lock after 4 commas, and the reconstructed 16'hbc95 appears with `k_o`=2'b10.
- **Loss of lock.** Once locked, inject 3 consecutive wrong-lane commas. Required response: `aligned_o` falls and `lock_loss_cnt_o`=1. With 2 wrong-lane commas followed by a good one, lock is retained.
- **Timeout.** Remove IDLEs from the stream. Required response: `aligned_o` falls after 400 cycles without a comma.
- **Permission and invalid.** With `realign_i`=0 and slipped commas, the block stays in HUNT with `offset_o`=0. Dropping `rx_valid_i` for 1 cycle while locked gives `valid_o`=0, `aligned_o`=0, and a relock later.
- **Async reset.** Pulse `rst_n_i` low between clock edges. Required response: all outputs return to reset values immediately, and `lock_loss_cnt_o`=0.

Source files
------------

// File: rtl/rx_byte_aligner_pkg.sv
// Shared constants, counter widths and FSM encoding for the RX byte aligner.
package rx_byte_aligner_pkg;

    localparam logic [15:0] g_IDLE          = 16'hbc95;
    localparam int          g_LOCK_COUNT    = 4;
    localparam int          g_LOSS_COUNT    = 3;
    localparam int          g_COMMA_TIMEOUT = 400;

    // K28.5 comma byte; it belongs in the high lane of an aligned IDLE word
    localparam logic [7:0] COMMA_BYTE = g_IDLE[15:8];

    localparam int TMO_W = $clog2(g_COMMA_TIMEOUT + 1);
    localparam int OK_W  = $clog2(g_LOCK_COUNT + 1);
    localparam int ERR_W = $clog2(g_LOSS_COUNT + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(g_COMMA_TIMEOUT - 1);
    localparam logic [OK_W-1:0]  OK_LAST  = OK_W'(g_LOCK_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(g_LOSS_COUNT - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_byte_aligner_shift.sv
// Previous-word register and one-byte offset mux with registered outputs.
module rx_byte_shift (
    input  logic        usrclk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic [15:0] data_i,
    input  logic [1:0]  k_i,
    input  logic        offset_i,
    output logic [15:0] data_o,
    output logic [1:0]  k_o,
    output logic        valid_o
);

    logic [15:0] prev_data_q;
    logic [1:0]  prev_k_q;
    logic        prev_valid_q;
    logic [15:0] data_d, data_q;
    logic [1:0]  k_d, k_q;
    logic        valid_d, valid_q;

    // With a one-byte slip the high output byte comes from the previous word's low lane
    always_comb begin
        data_d  = data_i;
        k_d     = k_i;
        if (offset_i) begin
            data_d = {prev_data_q[7:0], data_i[15:8]};
            k_d    = {prev_k_q[0], k_i[1]};
        end
        valid_d = valid_i && (!offset_i || prev_valid_q);
    end

    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_data_q  <= '0;
            prev_k_q     <= '0;
            prev_valid_q <= 1'b0;
            data_q       <= '0;
            k_q          <= '0;
            valid_q      <= 1'b0;
        end else begin
            prev_data_q  <= data_i;
            prev_k_q     <= k_i;
            prev_valid_q <= valid_i;
            data_q       <= data_d;
            k_q          <= k_d;
            valid_q      <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign k_o     = k_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rx_byte_aligner.sv
// RX byte aligner: comma detection, HUNT/VERIFY/LOCKED offset lock FSM and loss counter.
module rx_byte_aligner
    import rx_byte_aligner_pkg::*;
(
    input  logic        usrclk_i,
    input  logic        rst_n_i,
    input  logic        rx_valid_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    input  logic        realign_i,
    output logic [15:0] data_o,
    output logic [1:0]  k_o,
    output logic        valid_o,
    output logic        aligned_o,
    output logic        offset_o,
    output logic [7:0]  lock_loss_cnt_o
);

    state_e             state_q, state_d;
    logic               offset_q, offset_d;
    logic [OK_W-1:0]    ok_cnt_q, ok_cnt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]         loss_cnt_q, loss_cnt_d;

    logic hi_comma, lo_comma, one_comma, cand_offset;
    logic exp_comma, wrong_comma, timeout;

    always_comb begin
        hi_comma    = rx_k_i[1] && (rx_data_i[15:8] == COMMA_BYTE);
        lo_comma    = rx_k_i[0] && (rx_data_i[7:0] == COMMA_BYTE);
        one_comma   = hi_comma ^ lo_comma;
        cand_offset = lo_comma;
        exp_comma   = one_comma && (cand_offset == offset_q);
        // a comma in both lanes is never a candidate, so it always lands here
        wrong_comma = (hi_comma || lo_comma) && !exp_comma;
        timeout     = !exp_comma && (tmo_cnt_q >= TMO_LAST);
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        loss_cnt_d = loss_cnt_q;

        if (!rx_valid_i) begin
            state_d   = ST_HUNT;
            ok_cnt_d  = '0;
            err_cnt_d = '0;
            tmo_cnt_d = '0;
            if (state_q == ST_LOCKED) loss_cnt_d = sat_inc8(loss_cnt_q);
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (realign_i && one_comma) begin
                        offset_d  = cand_offset;
                        ok_cnt_d  = OK_W'(1);
                        err_cnt_d = '0;
                        tmo_cnt_d = '0;
                        state_d   = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (wrong_comma || timeout) begin
                        state_d   = ST_HUNT;
                        ok_cnt_d  = '0;
                        tmo_cnt_d = '0;
                    end else if (exp_comma) begin
                        ok_cnt_d  = ok_cnt_q + OK_W'(1);
                        tmo_cnt_d = '0;
                        if (ok_cnt_q == OK_LAST) state_d = ST_LOCKED;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if ((wrong_comma && (err_cnt_q == ERR_LAST)) || timeout) begin
                        state_d    = ST_HUNT;
                        ok_cnt_d   = '0;
                        err_cnt_d  = '0;
                        tmo_cnt_d  = '0;
                        loss_cnt_d = sat_inc8(loss_cnt_q);
                    end else if (wrong_comma) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end else if (exp_comma) begin
                        err_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_HUNT;
            offset_q   <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    // The shifter sees the next offset so the word after an acquiring comma is already shifted
    rx_byte_shift u_shift (
        .usrclk_i (usrclk_i),
        .rst_n_i  (rst_n_i),
        .valid_i  (rx_valid_i),
        .data_i   (rx_data_i),
        .k_i      (rx_k_i),
        .offset_i (offset_d),
        .data_o   (data_o),
        .k_o      (k_o),
        .valid_o  (valid_o)
    );

    assign aligned_o       = (state_q == ST_LOCKED);
    assign offset_o        = offset_q;
    assign lock_loss_cnt_o = loss_cnt_q;

endmodule
